video_cfg_sequencer: RTL

Frame-synchronous configuration controller for the video mixer path. It measures incoming raw video timing, including pixels per line and lines per frame, and declares timing lock. It gates the OSD's scandoubler, scanline and hq2x requests so they reach the mixer only at a VSync boundary, and only when the scandoubler line buffer can hold the line. It sits between the OSD/status bits and the mixer's `scandoubler`/`scanlines`/`hq2x` inputs. A `mute` output blanks the mixer output while the scandoubler is switching.

---
 rtl/video_cfg_pkg.sv | 18 +
 rtl/video_timing_meter.sv | 96 +++++++++
 rtl/video_cfg_sequencer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/video_cfg_pkg.sv
// rtl/video_cfg_pkg.sv - shared types and widths for the video config sequencer
package video_cfg_pkg;

    localparam int HPIX_W  = 12;
    localparam int VLINE_W = 11;

    typedef enum logic {
        RUN  = 1'b0,
        MUTE = 1'b1
    } state_t;

    typedef struct packed {
        logic       sd;
        logic [1:0] scanlines;
        logic       hq2x;
    } cfg_t;

endpackage

// File: rtl/video_timing_meter.sv
// rtl/video_timing_meter.sv - raw video timing measurement and frame lock detection
module video_timing_meter
    import video_cfg_pkg::*;
#(
    parameter int LOCK_FRAMES = 2,
    parameter int TIMEOUT     = 1 << 22
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               ce_pix,
    input  logic               HSync,
    input  logic               VSync,
    output logic               vs_fall,
    output logic [HPIX_W-1:0]  h_cur,
    output logic [HPIX_W-1:0]  h_pix,
    output logic [VLINE_W-1:0] v_lines,
    output logic               locked,
    output logic               locked_next
);

    localparam int                 TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]    TO_MAX   = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0]    TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [3:0]         LOCK_CNT = 4'(LOCK_FRAMES);

    logic               hs_d, vs_d, hs_fall;
    logic [HPIX_W-1:0]  pix_cnt, h_prev;
    logic [VLINE_W-1:0] line_cnt, v_prev;
    logic [3:0]         stable_cnt, stable_next;
    logic [TO_W-1:0]    to_cnt;
    logic               frame_match;

    assign hs_fall = hs_d & ~HSync;
    assign vs_fall = vs_d & ~VSync;

    // Lock decision for the frame ending in this cycle, also consumed by the top
    always_comb begin
        frame_match = (h_cur == h_prev) && (line_cnt == v_prev);
        stable_next = 4'd0;
        if (frame_match) begin
            stable_next = (stable_cnt == LOCK_CNT) ? stable_cnt : stable_cnt + 4'd1;
        end
        locked_next = (stable_next == LOCK_CNT);
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            hs_d       <= 1'b0;
            vs_d       <= 1'b0;
            pix_cnt    <= '0;
            h_cur      <= '0;
            line_cnt   <= '0;
            h_prev     <= '0;
            v_prev     <= '0;
            h_pix      <= '0;
            v_lines    <= '0;
            stable_cnt <= '0;
            locked     <= 1'b0;
            to_cnt     <= '0;
        end else begin
            hs_d <= HSync;
            vs_d <= VSync;

            if (hs_fall) begin
                h_cur   <= pix_cnt;
                pix_cnt <= {{(HPIX_W-1){1'b0}}, ce_pix};
            end else if (ce_pix && (pix_cnt != '1)) begin
                pix_cnt <= pix_cnt + 1'b1;
            end

            // A line whose HSync falls together with VSync belongs to the next frame
            if (vs_fall) begin
                line_cnt <= '0;
            end else if (hs_fall && (line_cnt != '1)) begin
                line_cnt <= line_cnt + 1'b1;
            end

            if (vs_fall) begin
                h_prev     <= h_cur;
                v_prev     <= line_cnt;
                h_pix      <= h_cur;
                v_lines    <= line_cnt;
                stable_cnt <= stable_next;
                locked     <= locked_next;
                to_cnt     <= '0;
            end else if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + 1'b1;
                if (to_cnt == TO_LAST) begin
                    stable_cnt <= '0;
                    locked     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/video_cfg_sequencer.sv
// rtl/video_cfg_sequencer.sv - VSync-aligned scandoubler/scanline/hq2x config gating with mute
module video_cfg_sequencer
    import video_cfg_pkg::*;
#(
    parameter int LINE_LENGTH = 768,
    parameter int LOCK_FRAMES = 2,
    parameter int MUTE_FRAMES = 2,
    parameter int TIMEOUT     = 1 << 22
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               ce_pix,
    input  logic               HSync,
    input  logic               VSync,
    input  logic               req_scandoubler,
    input  logic [1:0]         req_scanlines,
    input  logic               req_hq2x,
    output logic               scandoubler,
    output logic [1:0]         scanlines,
    output logic               hq2x,
    output logic               mute,
    output logic               locked,
    output logic [HPIX_W-1:0]  h_pix,
    output logic [VLINE_W-1:0] v_lines,
    output logic               apply_stb
);

    localparam logic [3:0]        MUTE_LOAD = 4'(MUTE_FRAMES);
    localparam logic [HPIX_W-1:0] LINE_MAX  = HPIX_W'(LINE_LENGTH);

    logic              vs_fall, locked_next;
    logic [HPIX_W-1:0] h_cur;

    video_timing_meter #(
        .LOCK_FRAMES (LOCK_FRAMES),
        .TIMEOUT     (TIMEOUT)
    ) u_meter (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ce_pix      (ce_pix),
        .HSync       (HSync),
        .VSync       (VSync),
        .vs_fall     (vs_fall),
        .h_cur       (h_cur),
        .h_pix       (h_pix),
        .v_lines     (v_lines),
        .locked      (locked),
        .locked_next (locked_next)
    );

    state_t     state_q, state_n;
    cfg_t       cfg_q, cfg_n, target;
    logic [3:0] mute_cnt, mute_cnt_n;
    logic       mute_q, mute_n, stb_q, stb_n, sd_t, sd_change;

    // The scandoubler only engages on a locked timing whose lines fit the buffer
    always_comb begin
        sd_t             = req_scandoubler & locked_next & (h_cur <= LINE_MAX);
        target.sd        = sd_t;
        target.scanlines = req_scanlines;
        target.hq2x      = req_hq2x & sd_t;
    end

    always_comb begin
        state_n    = state_q;
        cfg_n      = cfg_q;
        mute_n     = mute_q;
        mute_cnt_n = mute_cnt;
        stb_n      = 1'b0;
        sd_change  = (target.sd != cfg_q.sd);
        if (vs_fall) begin
            if (target != cfg_q) begin
                cfg_n = target;
                stb_n = 1'b1;
            end
            case (state_q)
                RUN: begin
                    if (sd_change) begin
                        mute_n     = 1'b1;
                        mute_cnt_n = MUTE_LOAD;
                        state_n    = MUTE;
                    end
                end
                MUTE: begin
                    if (sd_change) begin
                        mute_cnt_n = MUTE_LOAD;
                    end else if (mute_cnt <= 4'd1) begin
                        mute_cnt_n = 4'd0;
                        mute_n     = 1'b0;
                        state_n    = RUN;
                    end else begin
                        mute_cnt_n = mute_cnt - 4'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q  <= MUTE;
            cfg_q    <= '0;
            mute_q   <= 1'b1;
            mute_cnt <= MUTE_LOAD;
            stb_q    <= 1'b0;
        end else begin
            state_q  <= state_n;
            cfg_q    <= cfg_n;
            mute_q   <= mute_n;
            mute_cnt <= mute_cnt_n;
            stb_q    <= stb_n;
        end
    end

    assign scandoubler = cfg_q.sd;
    assign scanlines   = cfg_q.scanlines;
    assign hq2x        = cfg_q.hq2x;
    assign mute        = mute_q;
    assign apply_stb   = stb_q;

endmodule
